// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Program loader. Accepts symbolic instructions (mnemonic + fields)
//            over a valid/ready handshake, packs each into a 32-bit MIPS word
//            and writes the words to consecutive imem word addresses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1     clock, rising edge
//   reset      in   1     synchronous reset, active-low
//   start      in   1     pulse: open a new session at base
//   base       in   AW    first imem word address of the session
//   in_valid   in   1     instruction fields valid
//   in_ready   out  1     encoder can accept this cycle
//   mnem       in   4     0 LW,1 SW,2 BEQ,3 ADDI,4 ADDIU,5 J,6 LUI,7 ORI,
//                         8 ADD,9 SUB,10 AND,11 OR,12 SLT (13..15 illegal)
//   rs,rt,rd   in   5     register fields
//   imm        in   16    immediate / branch offset
//   target     in   26    jump target field
//   imem_we    out  1     imem write strobe
//   imem_addr  out  AW    imem word address
//   imem_wdata out  32    encoded instruction
//   count      out  AW+1  words accepted this session
//   full       out  1     session holds DEPTH words
//   err        out  1     illegal mnemonic seen this session
// ============================================================================
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    mnem,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;      // address of the next word to write
  logic [AW:0]   count_q, count_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          w_accept;
  logic          w_legal;
  logic [31:0]   w_enc;

  // Ready depends only on state and start so a start pulse always wins.
  assign in_ready = (state_q == S_RUN) && !start;
  assign w_accept = in_valid && in_ready;
  assign w_legal  = (mnem <= 4'd12);

  always_comb begin
    w_enc = 32'h0;
    case (mnem)
      4'd0:    w_enc = {6'h23, rs, rt, imm};
      4'd1:    w_enc = {6'h2B, rs, rt, imm};
      4'd2:    w_enc = {6'h04, rs, rt, imm};
      4'd3:    w_enc = {6'h08, rs, rt, imm};
      4'd4:    w_enc = {6'h09, rs, rt, imm};
      4'd5:    w_enc = {6'h02, target};
      4'd6:    w_enc = {6'h0F, 5'd0, rt, imm};   // LUI has no rs operand
      4'd7:    w_enc = {6'h0D, rs, rt, imm};
      4'd8:    w_enc = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd9:    w_enc = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd10:   w_enc = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd11:   w_enc = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd12:   w_enc = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      default: w_enc = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = S_RUN;
      ptr_d   = base;
      count_d = '0;
    end else if (w_accept) begin
      if (!w_legal) begin
        state_d = S_ERR;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = w_enc;
        ptr_d   = ptr_q + AW'(1);               // wraps modulo 2**AW
        count_d = count_q + (AW+1)'(1);
        if (count_q + (AW+1)'(1) == C_DEPTH) begin
          state_d = S_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (state_q == S_FULL);
  assign err        = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Scoreboard bench for instr_encoder. A driver issues directed and
//            random instructions, predicts each write from a behavioural
//            session model and queues it; a monitor pops and compares every
//            imem write as the DUT presents it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    mnem = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Session model: 0 idle, 1 accepting, 2 full, 3 error.
  int m_mode  = 0;
  int m_count = 0;
  int m_next  = 0;

  int          clear_at   = -1;
  logic [5:0]  last_addr  = '0;
  logic [31:0] last_wdata = '0;

  int op_of    [8] = '{'h23, 'h2B, 'h04, 'h08, 'h09, 'h02, 'h0F, 'h0D};
  int funct_of [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};

  function automatic logic [31:0] enc(input int mn, input int r_s, input int r_t,
                                      input int r_d, input int im, input int tg);
    longint r;
    if (mn >= 8)
      r = (longint'(r_s) << 21) | (longint'(r_t) << 16) | (longint'(r_d) << 11) | funct_of[mn-8];
    else if (mn == 5)
      r = (longint'(op_of[mn]) << 26) | longint'(tg);
    else if (mn == 6)
      r = (longint'(op_of[mn]) << 26) | (longint'(r_t) << 16) | longint'(im);
    else
      r = (longint'(op_of[mn]) << 26) | (longint'(r_s) << 21) | (longint'(r_t) << 16) | longint'(im);
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model advances as the coming edge will.
  task automatic step(input bit rn, input bit st, input int b, input bit v, input int mn,
                      input int r_s, input int r_t, input int r_d, input int im, input int tg);
    @(negedge clk);
    reset = rn; start = st; base = b[5:0]; in_valid = v; mnem = mn[3:0];
    rs = r_s[4:0]; rt = r_t[4:0]; rd = r_d[4:0]; imm = im[15:0]; target = tg[25:0];
    #1;
    chk("in_ready", 64'(in_ready), 64'(m_mode == 1 && !st));
    chk("full", 64'(full), 64'(m_mode == 2));
    chk("err", 64'(err), 64'(m_mode == 3));
    chk("count", 64'(count), 64'(m_count));
    if (!rn) begin
      m_mode = 0; m_count = 0; m_next = 0;
      clear_at = cyc + 1;
    end else if (st) begin
      m_mode = 1; m_count = 0; m_next = b % 64;
    end else if (m_mode == 1 && v) begin
      if (mn > 12) begin
        m_mode = 3;
      end else begin
        exp_t e;
        e.due = cyc + 1;
        e.addr = m_next[5:0];
        e.wdata = enc(mn, r_s, r_t, r_d, im, tg);
        q.push_back(e);
        m_next = (m_next + 1) % 64;
        m_count++;
        if (m_count == DEPTH) m_mode = 2;
      end
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pin the most recently predicted word to a known-answer value.
  task automatic expect_word(input logic [31:0] w);
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL known_answer: got no accept expected 0x%0h", w);
    end else begin
      q[q.size()-1].wdata = w;
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (cyc == clear_at) begin
        last_addr = '0; last_wdata = '0;
      end
      if (imem_we === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_write: got we=1 addr=%0d data=0x%0h expected we=0", imem_addr, imem_wdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.due));
          chk("write_addr", 64'(imem_addr), 64'(e.addr));
          chk("write_data", 64'(imem_wdata), 64'(e.wdata));
          last_addr = e.addr; last_wdata = e.wdata;
        end
      end else begin
        chk("imem_we", 64'(imem_we), 64'(0));
        if (q.size() > 0 && q[0].due <= cyc) begin
          exp_t e;
          e = q.pop_front();
          checks++; errors++;
          $display("FAIL missing_write: got we=0 expected write addr=%0d data=0x%0h", e.addr, e.wdata);
        end
        chk("hold_addr", 64'(imem_addr), 64'(last_addr));
        chk("hold_data", 64'(imem_wdata), 64'(last_wdata));
      end
    end
  end

  // Driver
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1, 1, 1, 1, 1);
    idle();
    // Session at 0: known-answer words, fourth accept fills the session.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0, 2, 0, 5, 0);          expect_word(32'h20020005);
    step(1, 0, 0, 1, 0, 0, 2, 0, 'h50, 0);       expect_word(32'h8C020050);
    step(1, 0, 0, 1, 8, 1, 2, 3, 0, 0);          expect_word(32'h00221820);
    step(1, 0, 0, 1, 5, 0, 0, 0, 0, 'h11);       expect_word(32'h08000011);
    step(1, 0, 0, 1, 3, 1, 1, 1, 1, 0);          // FULL: not accepted
    // start with valid in the same cycle: accept dropped
    step(1, 1, 10, 1, 3, 1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 6, 7, 4, 0, 'h1234, 0);     expect_word(32'h3C041234);
    step(1, 0, 0, 1, 2, 1, 2, 0, 'hFFFF, 0);     expect_word(32'h1022FFFF);
    step(1, 0, 0, 1, 14, 1, 2, 3, 4, 5);         // illegal -> ERR
    step(1, 0, 0, 1, 3, 1, 1, 1, 1, 0);
    idle();
    // Address wrap near the top of imem
    step(1, 1, 62, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 9, i, i + 1, i + 2, 0, 0);
    idle();
    // Reset right after an accept, then reset coincident with an accept
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 7, 3, 4, 0, 'hBEEF, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 1, 20, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 3, 4, 0, 'h1111, 0);
    idle();
    idle();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 32'h3FFFFFF)));
    end
    idle();
    idle();
    idle();
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
